// File: rtl/timer_capture_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timer_capture_pkg
//  Description : Shared types and widths for the PWM input-capture channel.
//  Revision    : 1.0 - initial release
// ============================================================================
package timer_capture_pkg;

    // Width of the prescaler reload value and of the signal selector
    localparam int CAPT_PRESC_W = 8;
    localparam int CAPT_SEL_W   = 8;

    // Measurement sequencer states
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        HIGH = 3'd2,
        LOW  = 3'd3,
        DONE = 3'd4
    } capture_state_e;

endpackage : timer_capture_pkg
`default_nettype wire

// File: rtl/capture_edge_det.sv
`default_nettype none
// ============================================================================
//  Module      : capture_edge_det
//  Description : Selects one external signal, optionally inverts it,
//                synchronises it with two flops and produces single-cycle
//                rise/fall pulses from a further delay flop.
//  Revision    : 1.0 - initial release
// ============================================================================
module capture_edge_det
    import timer_capture_pkg::*;
#(
    parameter int N_EXTSIG = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CAPT_SEL_W-1:0] i_sel,
    input  logic                  i_invert,
    input  logic [N_EXTSIG-1:0]   i_signal,
    output logic                  o_rise,
    output logic                  o_fall
);

    logic w_pick;
    logic w_level;
    logic r_s1;
    logic r_s2;
    logic r_d;

    // Signal mux: an index past the end of the bus reads as constant 0
    always_comb begin
        w_pick = 1'b0;
        for (int i = 0; i < N_EXTSIG; i++) begin
            if (i_sel == CAPT_SEL_W'(i)) begin
                w_pick = i_signal[i];
            end
        end
    end

    assign w_level = w_pick ^ i_invert;

    // Two-flop synchroniser followed by a delay flop for edge comparison
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_d  <= 1'b0;
        end else begin
            r_s1 <= w_level;
            r_s2 <= r_s1;
            r_d  <= r_s2;
        end
    end

    assign o_rise = r_s2 & ~r_d;
    assign o_fall = ~r_s2 & r_d;

endmodule : capture_edge_det
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_capture
//  Description : PWM input-capture channel. Measures high time and period of
//                a selected external signal in prescaled ticks and presents
//                each result on a valid/ready interface.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_capture
    import timer_capture_pkg::*;
#(
    parameter int NUM_BITS = 16,
    parameter int N_EXTSIG = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cfg_en_i,
    input  logic                    cfg_single_i,
    input  logic                    cfg_invert_i,
    input  logic [CAPT_SEL_W-1:0]   cfg_sel_i,
    input  logic [CAPT_PRESC_W-1:0] cfg_presc_i,
    input  logic [N_EXTSIG-1:0]     signal_i,
    output logic                    meas_valid_o,
    input  logic                    meas_ready_i,
    output logic [NUM_BITS-1:0]     meas_high_o,
    output logic [NUM_BITS-1:0]     meas_period_o,
    output logic                    meas_ovf_o,
    output logic                    evt_drop_o,
    output logic                    busy_o
);

    localparam logic [NUM_BITS-1:0] c_cnt_max = '1;

    capture_state_e            r_state;
    capture_state_e            w_state_next;

    logic                      w_rise;
    logic                      w_fall;
    logic                      w_tick;
    logic                      w_cnt_sat;
    logic [NUM_BITS-1:0]       w_cnt_next;
    logic                      w_ovf_next;
    logic                      w_start;
    logic                      w_latch_high;
    logic                      w_complete;

    logic [CAPT_PRESC_W-1:0]   r_pcnt;
    logic [NUM_BITS-1:0]       r_cnt;
    logic                      r_ovf;
    logic [NUM_BITS-1:0]       r_hi_lat;

    logic                      r_valid;
    logic [NUM_BITS-1:0]       r_high;
    logic [NUM_BITS-1:0]       r_period;
    logic                      r_out_ovf;
    logic                      r_drop;

    capture_edge_det #(
        .N_EXTSIG (N_EXTSIG)
    ) u_edge_det (
        .clk      (clk_i),
        .rst      (rst_i),
        .i_sel    (cfg_sel_i),
        .i_invert (cfg_invert_i),
        .i_signal (signal_i),
        .o_rise   (w_rise),
        .o_fall   (w_fall)
    );

    // Tick and saturating counter arithmetic; the result captures cnt_next so
    // the tick of the terminating edge cycle is included
    assign w_tick     = (r_pcnt == cfg_presc_i);
    assign w_cnt_sat  = (r_cnt == c_cnt_max);
    assign w_cnt_next = w_cnt_sat ? r_cnt : (r_cnt + NUM_BITS'(w_tick));
    assign w_ovf_next = r_ovf | (w_cnt_sat & w_tick);

    // Sequencer state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and event decode; a dropped enable overrides everything
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_latch_high = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_next = ARM;
            end
            ARM: begin
                if (w_rise) begin
                    w_start      = 1'b1;
                    w_state_next = HIGH;
                end
            end
            HIGH: begin
                if (w_fall) begin
                    w_latch_high = 1'b1;
                    w_state_next = LOW;
                end
            end
            LOW: begin
                if (w_rise) begin
                    w_complete = 1'b1;
                    if (cfg_single_i) begin
                        w_state_next = DONE;
                    end else begin
                        // Same rise opens the next measurement: no lost edge
                        w_start      = 1'b1;
                        w_state_next = HIGH;
                    end
                end
            end
            DONE: begin
                w_state_next = DONE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
        if (!cfg_en_i) begin
            w_state_next = IDLE;
            w_start      = 1'b0;
            w_latch_high = 1'b0;
            w_complete   = 1'b0;
        end
    end

    // Prescaler: restarts with each measurement, parked while not measuring
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pcnt <= '0;
        end else if (w_start || (r_state == IDLE) || (r_state == DONE)) begin
            r_pcnt <= '0;
        end else if (w_tick) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + CAPT_PRESC_W'(1);
        end
    end

    // Measurement counter and overflow flag, cleared at measurement start
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_start) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if ((r_state == HIGH) || (r_state == LOW)) begin
            r_cnt <= w_cnt_next;
            r_ovf <= w_ovf_next;
        end
    end

    // High-time latch taken at the falling edge
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_hi_lat <= '0;
        end else if (w_latch_high) begin
            r_hi_lat <= w_cnt_next;
        end
    end

    // Output register: a pending unaccepted result wins over a new one
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid   <= 1'b0;
            r_high    <= '0;
            r_period  <= '0;
            r_out_ovf <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            r_drop <= 1'b0;
            if (w_complete) begin
                if (r_valid && !meas_ready_i) begin
                    r_drop <= 1'b1;
                end else begin
                    r_valid   <= 1'b1;
                    r_high    <= r_hi_lat;
                    r_period  <= w_cnt_next;
                    r_out_ovf <= w_ovf_next;
                end
            end else if (r_valid && meas_ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign meas_valid_o  = r_valid;
    assign meas_high_o   = r_high;
    assign meas_period_o = r_period;
    assign meas_ovf_o    = r_out_ovf;
    assign evt_drop_o    = r_drop;
    assign busy_o        = (r_state == ARM) || (r_state == HIGH) || (r_state == LOW);

endmodule : pwm_capture
`default_nettype wire

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
Input-capture channel that reads back PWM-style waveforms, the receive-side counterpart of the timer's PWM generator. It selects one external signal from the signal_i bus, synchronises it and detects its edges. It then measures high time and period in prescaled clock ticks and presents each result on a valid/ready interface to the APB register block. It sits beside timer_module in the advanced timer and shares its signal_i bus.

Parameters:
NUM_BITS, 16, width of the measurement counter and result fields
N_EXTSIG, 32, width of the external signal bus

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous, active-high reset
cfg_en_i  in  1  enable; 0 forces IDLE
cfg_single_i  in  1  1 = one-shot measurement, 0 = continuous
cfg_invert_i  in  1  invert the selected input, so low time is measured as "high"
cfg_sel_i  in  8  signal index; an index of N_EXTSIG or above selects constant 0
cfg_presc_i  in  8  one tick every cfg_presc_i+1 cycles
signal_i  in  N_EXTSIG  external asynchronous signals
meas_valid_o  out  1  result available
meas_ready_i  in  1  consumer accepts result
meas_high_o  out  NUM_BITS  high time in ticks
meas_period_o  out  NUM_BITS  period in ticks
meas_ovf_o  out  1  counter saturated during this measurement
evt_drop_o  out  1  one-cycle pulse: a completed result was discarded
busy_o  out  1  state is ARM, HIGH or LOW

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, sync flops 0.
- Input path:
  - mux, then optional invert, then s1, s2, d flops. These run in every state.
  - rise = s2 & ~d, fall = ~s2 & d.
  - A pin change appears as an edge pulse 2 cycles after s1 samples it.
  - A signal already high at reset release produces one genuine rise.
- Prescaler: 8-bit pcnt.
  - tick = (pcnt == cfg_presc_i); pcnt wraps to 0 on tick.
  - pcnt is cleared on a start-rise and held at 0 in IDLE and DONE.
- Counter cnt, NUM_BITS wide:
  - Cleared in the cycle a measurement starts.
  - cnt_next = cnt + tick, saturating at all-ones.
  - Saturation sets the internal ovf flag; ovf is cleared at measurement start.
- FSM:
  - IDLE -> ARM when cfg_en_i=1.
  - ARM: ignore fall. On rise: clear cnt and ovf, go to HIGH.
  - HIGH: on fall, hi_lat <= cnt_next, go to LOW. A rise cannot occur in HIGH.
  - LOW: on rise, complete the result {hi_lat, cnt_next, ovf}.
    - If cfg_single_i=1, go to DONE.
    - Otherwise clear cnt and ovf and go to HIGH; this rise starts the next measurement, with no lost edge.
  - DONE -> IDLE when cfg_en_i=0.
  - cfg_en_i=0 in any state: next state IDLE and the in-flight measurement is discarded. The output register is unaffected.
- Result semantics: the value counts ticks in cycles t0+1..t1 inclusive. t0 is the starting rise-detect cycle and t1 the terminating edge cycle. With cfg_presc_i=0 this gives exactly H cycles of high time and P cycles of period.
- Output handshake:
  - A completed result loads the output register and sets meas_valid_o the next cycle.
  - Data stays stable while valid=1 and ready=0.
  - valid & ready clears valid.
  - Completion while valid=1 and ready=0: the new result is dropped, evt_drop_o pulses, and the old result is held.
  - Completion in the same cycle as valid & ready: the new result loads and valid stays 1.
- A saturated, stuck signal keeps the FSM waiting; there is no timeout.
- cfg_sel_i, cfg_invert_i and cfg_presc_i are only changed in IDLE. Behaviour under a mid-measurement change: the measurement continues with the new values, with no guarantee on that result.

Decomposition:
- Package timer_capture_pkg: capture_state_e {IDLE, ARM, HIGH, LOW, DONE}, plus the CAPT_PRESC_W=8 and CAPT_SEL_W=8 constants.
- Sub-module capture_edge_det: mux, invert, 2-flop synchroniser, delay flop, rise/fall outputs, synchronous active-high reset.
- The FSM, prescaler, counter and output register stay in pwm_capture.

Test Plan:
- presc=0, continuous, signal[3] with 30 cycles high and 100-cycle period, sel=3 -> first valid shows high=30, period=100, ovf=0. Every subsequent period yields the same result with no gap.
- presc=3, same waveform, one-shot -> exactly one result with high=7 or 8 and period=25. FSM then sits in DONE with busy_o=0; en=0 returns it to IDLE.
- invert=1, 30 cycles high / 100 period -> high=70, period=100.
- ready held 0 over 3 periods -> first result held stable, evt_drop_o pulses twice. Raising ready in the cycle of the 4th completion -> 4th result loads and valid stays 1.
- NUM_BITS=8, presc=0, 400-cycle period -> high and period saturate at 255 with ovf=1. The next normal-length measurement reports ovf=0.
- cfg_en_i dropped mid-HIGH, or rst_i asserted mid-LOW -> no result is produced, state is IDLE next cycle, busy_o=0. rst_i additionally clears valid and data to 0.
